// File: rtl/instr_encoder.sv
// instr_encoder: turns field-level instruction requests into 32-bit MIPS words
// and writes them sequentially into instruction memory. LI is expanded into
// LUI+ORI when its upper half is non-zero, otherwise it becomes a single ORI.
// All outputs are registered except that req_ready is gated by clear so that
// a clear always wins over a simultaneous request.

module instr_encoder #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_kind,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_shamt,
    input  logic [5:0]        req_funct,
    input  logic [31:0]       req_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_cnt,
    output logic              full,
    output logic              err_illegal,
    output logic              err_overflow
);

    localparam int CNT_W = ADDR_W + 1;

    // Word counter reaches DEPTH at most, which fits in ADDR_W+1 bits.
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    // Request kinds
    localparam logic [3:0] KIND_R    = 4'd0;
    localparam logic [3:0] KIND_ADDI = 4'd1;
    localparam logic [3:0] KIND_ORI  = 4'd2;
    localparam logic [3:0] KIND_ANDI = 4'd3;
    localparam logic [3:0] KIND_LUI  = 4'd4;
    localparam logic [3:0] KIND_LW   = 4'd5;
    localparam logic [3:0] KIND_SW   = 4'd6;
    localparam logic [3:0] KIND_BEQ  = 4'd7;
    localparam logic [3:0] KIND_BNE  = 4'd8;
    localparam logic [3:0] KIND_J    = 4'd9;
    localparam logic [3:0] KIND_JAL  = 4'd10;
    localparam logic [3:0] KIND_LI   = 4'd11;

    // MIPS primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_EMIT_HI = 2'd2,
        ST_EMIT_LO = 2'd3
    } state_t;

    // I-type word: opcode, rs, rt, 16-bit immediate
    function automatic logic [31:0] enc_itype(
        input logic [5:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm16
    );
        return {op, rs, rt, imm16};
    endfunction

    // J-type word: opcode plus word index of the byte target
    function automatic logic [31:0] enc_jtype(
        input logic [5:0]  op,
        input logic [31:0] byte_target
    );
        return {op, byte_target[27:2]};
    endfunction

    state_t            state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       pend_word_q, pend_word_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              full_q, full_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_overflow_q, err_overflow_d;
    logic              req_ready_q, req_ready_d;

    logic [31:0]       first_word_s;
    logic [31:0]       second_word_s;
    logic              two_word_s;
    logic              illegal_s;
    logic [CNT_W-1:0]  free_s;
    logic              overflow_s;
    logic              accept_s;

    // Encode the current request fields into one or two instruction words
    always_comb begin
        first_word_s  = 32'h0000_0000;
        second_word_s = 32'h0000_0000;
        two_word_s    = 1'b0;
        illegal_s     = 1'b0;
        case (req_kind)
            KIND_R:    first_word_s = {OP_RTYPE, req_rs, req_rt, req_rd, req_shamt, req_funct};
            KIND_ADDI: first_word_s = enc_itype(OP_ADDI, req_rs, req_rt, req_imm[15:0]);
            KIND_ORI:  first_word_s = enc_itype(OP_ORI,  req_rs, req_rt, req_imm[15:0]);
            KIND_ANDI: first_word_s = enc_itype(OP_ANDI, req_rs, req_rt, req_imm[15:0]);
            KIND_LUI:  first_word_s = enc_itype(OP_LUI,  5'd0,   req_rt, req_imm[15:0]);
            KIND_LW:   first_word_s = enc_itype(OP_LW,   req_rs, req_rt, req_imm[15:0]);
            KIND_SW:   first_word_s = enc_itype(OP_SW,   req_rs, req_rt, req_imm[15:0]);
            KIND_BEQ:  first_word_s = enc_itype(OP_BEQ,  req_rs, req_rt, req_imm[15:0]);
            KIND_BNE:  first_word_s = enc_itype(OP_BNE,  req_rs, req_rt, req_imm[15:0]);
            KIND_J:    first_word_s = enc_jtype(OP_J,   req_imm);
            KIND_JAL:  first_word_s = enc_jtype(OP_JAL, req_imm);
            KIND_LI: begin
                if (req_imm[31:16] == 16'h0000) begin
                    // Small constant: a single ORI from $0 is enough
                    first_word_s = enc_itype(OP_ORI, 5'd0, req_rt, req_imm[15:0]);
                end else begin
                    two_word_s    = 1'b1;
                    first_word_s  = enc_itype(OP_LUI, 5'd0,   req_rt, req_imm[31:16]);
                    second_word_s = enc_itype(OP_ORI, req_rt, req_rt, req_imm[15:0]);
                end
            end
            default:   illegal_s = 1'b1;
        endcase
    end

    // Handshake and capacity checks for the incoming request
    always_comb begin
        req_ready  = req_ready_q & ~clear;
        accept_s   = req_valid & req_ready & (state_q == ST_IDLE);
        free_s     = DEPTH_C - word_cnt_q;
        overflow_s = two_word_s & (free_s == CNT_W'(1));
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        mem_we_d       = 1'b0;
        mem_wdata_d    = mem_wdata_q;
        pend_word_d    = pend_word_q;
        word_cnt_d     = word_cnt_q;
        err_illegal_d  = err_illegal_q;
        err_overflow_d = err_overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    word_cnt_d     = {CNT_W{1'b0}};
                    err_illegal_d  = 1'b0;
                    err_overflow_d = 1'b0;
                end else if (accept_s) begin
                    if (illegal_s) begin
                        // Consume the request, write nothing
                        err_illegal_d = 1'b1;
                        state_d       = ST_EMIT;
                    end else if (overflow_s) begin
                        // LI needs two slots but only one is left
                        err_overflow_d = 1'b1;
                        state_d        = ST_EMIT;
                    end else if (two_word_s) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = first_word_s;
                        pend_word_d = second_word_s;
                        state_d     = ST_EMIT_HI;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = first_word_s;
                        state_d     = ST_EMIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                // A rejected request passes through here with no strobe
                if (mem_we_q) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                end else begin
                    word_cnt_d = word_cnt_q;
                end
                state_d = ST_IDLE;
            end
            ST_EMIT_HI: begin
                word_cnt_d  = word_cnt_q + CNT_W'(1);
                mem_we_d    = 1'b1;
                mem_wdata_d = pend_word_q;
                state_d     = ST_EMIT_LO;
            end
            ST_EMIT_LO: begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // The address always tracks the next free slot, so the LO word
        // automatically lands one above the HI word.
        mem_addr_d  = BASE_C + word_cnt_d[ADDR_W-1:0];
        full_d      = (word_cnt_d == DEPTH_C);
        req_ready_d = (state_d == ST_IDLE) & ~full_d;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= BASE_C;
            mem_wdata_q    <= 32'h0000_0000;
            pend_word_q    <= 32'h0000_0000;
            word_cnt_q     <= {CNT_W{1'b0}};
            full_q         <= 1'b0;
            err_illegal_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            req_ready_q    <= 1'b1;
        end else begin
            state_q        <= state_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            pend_word_q    <= pend_word_d;
            word_cnt_q     <= word_cnt_d;
            full_q         <= full_d;
            err_illegal_q  <= err_illegal_d;
            err_overflow_q <= err_overflow_d;
            req_ready_q    <= req_ready_d;
        end
    end

    // Drive outputs from their registers
    always_comb begin
        mem_we       = mem_we_q;
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        word_cnt     = word_cnt_q;
        full         = full_q;
        err_illegal  = err_illegal_q;
        err_overflow = err_overflow_q;
    end

endmodule
